// File: rtl/vector_exec_unit.sv
// rtl/vector_exec_unit.sv - multi-cycle predicated vector ALU, LANES elements per cycle
// Operands are captured at accept; result chunks are merged in place while RUN walks idx.
module vector_exec_unit #(
   parameter int WIDTH        = 24,
   parameter int VECTOR_WIDTH = 8,
   parameter int LANES        = 2
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 start,
   output logic                                 ready,
   input  logic [2:0]                           aluControl,
   input  logic                                 scalarMode,
   input  logic                                 maskEn,
   input  logic [VECTOR_WIDTH-1:0]              mask,
   input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   vecA,
   input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   vecB,
   input  logic [WIDTH-1:0]                     scalarB,
   output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   result,
   output logic                                 done,
   output logic                                 busy,
   output logic                                 allZero,
   output logic                                 anyNeg
);

   localparam int IW = $clog2(VECTOR_WIDTH) + 1;

   if (VECTOR_WIDTH % LANES != 0) begin : g_lanes_check
      $error("vector_exec_unit: VECTOR_WIDTH must be a multiple of LANES");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                               state_q, state_d;
   logic [IW-1:0]                        idx_q, idx_d;
   logic [2:0]                           op_q, op_d;
   logic                                 scalar_mode_q, scalar_mode_d;
   logic                                 mask_en_q, mask_en_d;
   logic [VECTOR_WIDTH-1:0]              mask_q, mask_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   vec_a_q, vec_a_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   vec_b_q, vec_b_d;
   logic [WIDTH-1:0]                     scalar_b_q, scalar_b_d;
   logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   result_q, result_d;
   logic                                 all_zero_q, all_zero_d;
   logic                                 any_neg_q, any_neg_d;

   function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return a ^ b;
         3'b101:  return (int'(sh) >= WIDTH) ? '0 : (a << sh);
         3'b110:  return (int'(sh) >= WIDTH) ? '0 : (a >> sh);
         default: return b;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      op_d          = op_q;
      scalar_mode_d = scalar_mode_q;
      mask_en_d     = mask_en_q;
      mask_d        = mask_q;
      vec_a_d       = vec_a_q;
      vec_b_d       = vec_b_q;
      scalar_b_d    = scalar_b_q;
      result_d      = result_q;
      all_zero_d    = all_zero_q;
      any_neg_d     = any_neg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_RUN;
               idx_d         = '0;
               op_d          = aluControl;
               scalar_mode_d = scalarMode;
               mask_en_d     = maskEn;
               mask_d        = mask;
               vec_a_d       = vecA;
               vec_b_d       = vecB;
               scalar_b_d    = scalarB;
            end
         end
         S_RUN: begin
            // Only the current chunk is written; predicated-off elements merge the old value.
            for (int i = 0; i < VECTOR_WIDTH; i++) begin
               if (i >= int'(idx_q) && i < int'(idx_q) + LANES && (!mask_en_q || mask_q[i]))
                  result_d[i] = alu_op(op_q, vec_a_q[i],
                                       scalar_mode_q ? scalar_b_q : vec_b_q[i]);
            end
            idx_d = idx_q + IW'(LANES);
            if (idx_d == IW'(VECTOR_WIDTH)) begin
               state_d    = S_DONE;
               all_zero_d = (result_d == '0);
               any_neg_d  = 1'b0;
               for (int i = 0; i < VECTOR_WIDTH; i++)
                  any_neg_d = any_neg_d | result_d[i][WIDTH-1];
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         op_q          <= '0;
         scalar_mode_q <= 1'b0;
         mask_en_q     <= 1'b0;
         mask_q        <= '0;
         vec_a_q       <= '0;
         vec_b_q       <= '0;
         scalar_b_q    <= '0;
         result_q      <= '0;
         all_zero_q    <= 1'b0;
         any_neg_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         op_q          <= op_d;
         scalar_mode_q <= scalar_mode_d;
         mask_en_q     <= mask_en_d;
         mask_q        <= mask_d;
         vec_a_q       <= vec_a_d;
         vec_b_q       <= vec_b_d;
         scalar_b_q    <= scalar_b_d;
         result_q      <= result_d;
         all_zero_q    <= all_zero_d;
         any_neg_q     <= any_neg_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign busy    = !ready;
   assign done    = (state_q == S_DONE);
   assign result  = result_q;
   assign allZero = all_zero_q;
   assign anyNeg  = any_neg_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// tb/tb_vector_exec_unit.sv - scoreboard bench for vector_exec_unit (LANES=2 and LANES=8 instances)
module tb_vector_exec_unit;

   localparam int W   = 24;
   localparam int VW  = 8;
   localparam int NCH = 4;

   typedef logic [VW-1:0][W-1:0] vec_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          start8 = 1'b0;
   logic [2:0]    aluControl = '0;
   logic          scalarMode = 1'b0;
   logic          maskEn = 1'b0;
   logic [VW-1:0] mask = '0;
   vec_t          vecA = '0;
   vec_t          vecB = '0;
   logic [W-1:0]  scalarB = '0;

   logic ready, done, busy, allZero, anyNeg;
   vec_t result;
   logic ready8, done8, busy8, allZero8, anyNeg8;
   vec_t result8;

   int   nchecks = 0;
   int   nerr = 0;
   vec_t model_res = '0;
   vec_t model_res8 = '0;
   vec_t exp_q[$];

   always #5 clock = ~clock;

   vector_exec_unit #(.WIDTH(W), .VECTOR_WIDTH(VW), .LANES(2)) u_dut (
      .clock(clock), .reset(reset), .start(start), .ready(ready),
      .aluControl(aluControl), .scalarMode(scalarMode), .maskEn(maskEn), .mask(mask),
      .vecA(vecA), .vecB(vecB), .scalarB(scalarB), .result(result),
      .done(done), .busy(busy), .allZero(allZero), .anyNeg(anyNeg));

   vector_exec_unit #(.WIDTH(W), .VECTOR_WIDTH(VW), .LANES(8)) u_dut8 (
      .clock(clock), .reset(reset), .start(start8), .ready(ready8),
      .aluControl(aluControl), .scalarMode(scalarMode), .maskEn(maskEn), .mask(mask),
      .vecA(vecA), .vecB(vecB), .scalarB(scalarB), .result(result8),
      .done(done8), .busy(busy8), .allZero(allZero8), .anyNeg(anyNeg8));

   function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (b[4:0] > 5'd23) ? '0 : W'(a << b[4:0]);
         3'd6: r = (b[4:0] > 5'd23) ? '0 : W'(a >> b[4:0]);
         default: r = b;
      endcase
      return r;
   endfunction

   function automatic logic any_msb(input vec_t v);
      logic m = 1'b0;
      for (int i = 0; i < VW; i++) m = m | v[i][W-1];
      return m;
   endfunction

   // intr=1 pulses start (with altered operands) while the op is still running.
   task automatic run_op(input string name, input logic [2:0] op, input logic scal,
                         input logic men, input logic [VW-1:0] msk, input vec_t a,
                         input vec_t b, input logic [W-1:0] sb, input bit intr);
      vec_t old_res, new_res, part, got;
      old_res = model_res;
      for (int i = 0; i < VW; i++)
         new_res[i] = (!men || msk[i]) ? ref_alu(op, a[i], scal ? sb : b[i]) : old_res[i];
      exp_q.push_back(new_res);
      aluControl = op; scalarMode = scal; maskEn = men; mask = msk;
      vecA = a; vecB = b; scalarB = sb; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 1; k <= NCH + 1; k++) begin
         @(posedge clock); #1;
         if (intr && k == 1) begin
            start = 1'b1; vecA = ~a; vecB = ~b; scalarB = ~sb; aluControl = ~op; mask = ~msk;
         end
         if (intr && k == 2) start = 1'b0;
         if (k <= NCH) begin
            for (int i = 0; i < VW; i++) part[i] = (i < 2 * k) ? new_res[i] : old_res[i];
            nchecks++;
            if (result !== part) begin
               nerr++;
               $display("FAIL %s chunk%0d result got=%h exp=%h", name, k, result, part);
            end
         end
         nchecks++;
         if (done !== (k == NCH) || ready !== (k == NCH + 1) || busy !== (k <= NCH)) begin
            nerr++;
            $display("FAIL %s cycle%0d done/ready/busy got=%b%b%b exp=%b%b%b", name, k,
                     done, ready, busy, k == NCH, k == NCH + 1, k <= NCH);
         end
         if (k == NCH && done === 1'b1) begin
            nchecks++;
            if (exp_q.size() == 0) begin
               nerr++;
               $display("FAIL %s scoreboard empty at done, got=%h exp=entry", name, result);
            end else begin
               got = exp_q.pop_front();
               if (result !== got || allZero !== (got == '0) || anyNeg !== any_msb(got)) begin
                  nerr++;
                  $display("FAIL %s final got=%h z=%b n=%b exp=%h z=%b n=%b", name, result,
                           allZero, anyNeg, got, got == '0, any_msb(got));
               end
            end
         end
      end
      nchecks++;
      if (result !== new_res) begin
         nerr++;
         $display("FAIL %s hold result got=%h exp=%h", name, result, new_res);
      end
      model_res = new_res;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      nchecks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
          allZero !== 1'b0 || anyNeg !== 1'b0 || ready8 !== 1'b1) begin
         nerr++;
         $display("FAIL reset_state got r=%b b=%b d=%b z=%b n=%b res=%h exp r=1 b=0 d=0 z=0 n=0 res=0",
                  ready, busy, done, allZero, anyNeg, result);
      end
   endtask

   task automatic test_add();
      vec_t a, b;
      for (int i = 0; i < VW; i++) begin a[i] = W'(i); b[i] = W'(10 * i); end
      run_op("add", 3'd0, 1'b0, 1'b0, '0, a, b, '0, 1'b0);
   endtask

   task automatic test_wrap_flags();
      vec_t a, b;
      for (int i = 0; i < VW; i++) begin a[i] = 24'hFFFFFF; b[i] = 24'd1; end
      run_op("wrap_add", 3'd0, 1'b0, 1'b0, '0, a, b, '0, 1'b0);
      run_op("sub_neg", 3'd1, 1'b0, 1'b0, '0, '0, b, '0, 1'b0);
   endtask

   task automatic test_reset_midrun();
      vecA = '1; vecB = '1; aluControl = 3'd0; maskEn = 1'b0; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      @(posedge clock); #1 reset = 1'b1; start = 1'b1;
      @(posedge clock); #1 reset = 1'b0; start = 1'b0;
      nchecks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
          allZero !== 1'b0 || anyNeg !== 1'b0) begin
         nerr++;
         $display("FAIL reset_midrun got r=%b b=%b d=%b z=%b n=%b res=%h exp r=1 b=0 d=0 z=0 n=0 res=0",
                  ready, busy, done, allZero, anyNeg, result);
      end
      model_res = '0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         nchecks++;
         if (done !== 1'b0 || ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_after%0d got done=%b ready=%b exp done=0 ready=1", k, done, ready);
         end
      end
   endtask

   task automatic test_scalar_shift();
      vec_t a;
      for (int i = 0; i < VW; i++) a[i] = 24'd1;
      run_op("shl3", 3'd5, 1'b1, 1'b0, '0, a, '1, 24'd3, 1'b0);
      run_op("shl24", 3'd5, 1'b1, 1'b0, '0, a, '1, 24'd24, 1'b0);
      run_op("shr5", 3'd6, 1'b1, 1'b0, '0, {VW{24'h800000}}, '0, 24'd5, 1'b0);
   endtask

   task automatic test_mask_merge();
      run_op("fill55", 3'd7, 1'b0, 1'b0, '0, '0, {VW{24'h000055}}, '0, 1'b0);
      run_op("mask_aa", 3'd7, 1'b0, 1'b1, 8'b1010_0101, '0, {VW{24'h0000AA}}, '0, 1'b0);
   endtask

   task automatic test_random_ops();
      vec_t a, b;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < VW; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
         end
         run_op("rand", 3'($urandom_range(1, 6)), 1'b0, (it % 2) == 1, 8'($urandom), a, b,
                '0, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      vec_t a;
      for (int i = 0; i < VW; i++) a[i] = W'(i + 100);
      run_op("b2b_0", 3'd4, 1'b1, 1'b0, '0, a, '0, 24'h00F0F0, 1'b0);
      run_op("b2b_1", 3'd3, 1'b1, 1'b0, '0, a, '0, 24'h0F0000, 1'b0);
   endtask

   task automatic test_busy_ignore();
      vec_t a, b;
      for (int i = 0; i < VW; i++) begin a[i] = W'(3 * i + 1); b[i] = W'(i); end
      run_op("busy_ignore", 3'd0, 1'b0, 1'b0, '0, a, b, '0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         nchecks++;
         if (done !== 1'b0 || ready !== 1'b1 || result !== model_res) begin
            nerr++;
            $display("FAIL busy_ignore_idle%0d got done=%b ready=%b res=%h exp 0 1 %h", k, done,
                     ready, result, model_res);
         end
      end
   endtask

   task automatic test_lanes8();
      vec_t exp8;
      for (int i = 0; i < VW; i++) begin
         vecA[i] = W'($urandom); vecB[i] = W'($urandom);
         exp8[i] = ref_alu(3'd1, vecA[i], vecB[i]);
      end
      aluControl = 3'd1; scalarMode = 1'b0; maskEn = 1'b0; start8 = 1'b1;
      @(posedge clock); #1 start8 = 1'b0;
      @(posedge clock); #1;
      nchecks++;
      if (done8 !== 1'b1 || result8 !== exp8 || anyNeg8 !== any_msb(exp8)) begin
         nerr++;
         $display("FAIL lanes8_done got d=%b res=%h n=%b exp d=1 res=%h n=%b", done8, result8,
                  anyNeg8, exp8, any_msb(exp8));
      end
      @(posedge clock); #1;
      nchecks++;
      if (done8 !== 1'b0 || ready8 !== 1'b1) begin
         nerr++;
         $display("FAIL lanes8_ready got done=%b ready=%b exp done=0 ready=1", done8, ready8);
      end
      model_res8 = exp8;
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap_flags();
      test_reset_midrun();
      test_scalar_shift();
      test_mask_merge();
      test_random_ops();
      test_back_to_back();
      test_busy_ignore();
      test_lanes8();
      nchecks++;
      if (exp_q.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain got=%0d entries exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/vector_exec_unit.md
# vector_exec_unit

Multi-cycle vector execute engine for the 5-stage pipelined core. It accepts a full vector operand pair (or vector plus broadcast scalar) and processes `LANES` elements per cycle until all `VECTOR_WIDTH` elements are done. Masked-off elements keep their previous values. It sits beside the scalar execute stage and signals completion with a one-cycle `done` pulse. The pipeline stalls on `ready` = 0.

## Interface
- `WIDTH`, 24, element width in bits.
- `VECTOR_WIDTH`, 8, elements per vector.
- `LANES`, 2, elements computed per cycle. `VECTOR_WIDTH % LANES` must be 0; otherwise elaboration fails (`$error`).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted only when `ready` = 1.
- `ready`  out  1  high only in IDLE.
- `aluControl`  in  3  operation select, latched at accept.
- `scalarMode`  in  1  1: operand B element i = `scalarB` for all i. Latched at accept.
- `maskEn`  in  1  enable predication; latched at accept.
- `mask`  in  `VECTOR_WIDTH`  per-element enable (bit i ↔ element i); latched at accept.
- `vecA`, `vecB`  in  `[VECTOR_WIDTH-1:0][WIDTH-1:0]`  vector operands; latched at accept.
- `scalarB`  in  `WIDTH`  scalar operand; latched at accept.
- `result`  out  `[VECTOR_WIDTH-1:0][WIDTH-1:0]`  result register.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in RUN or DONE.
- `allZero`  out  1  every result element is 0; updated on entry to DONE.
- `anyNeg`  out  1  any result element has its MSB set; updated on entry to DONE.

## Operation
States:
- IDLE → RUN on `start && ready`. Operands and controls are latched and `idx` ← 0.
- RUN: every edge, elements `idx` .. `idx+LANES-1` are computed and written to `result`, then `idx` += `LANES`. The edge that writes the last chunk (`idx+LANES == VECTOR_WIDTH`) moves to DONE.
- DONE → IDLE unconditionally after one cycle.

Output decode:
- `ready` = (state == IDLE); `busy` = !`ready`; `done` = (state == DONE).

ALU ops, per element, results truncated modulo 2^`WIDTH`:
- 000 A+B
- 001 A−B
- 010 A&B
- 011 A|B
- 100 A^B
- 101 A<<B[4:0]
- 110 A>>B[4:0] (logical)
- 111 B

Shifts: if `B[4:0] >= WIDTH`, the result is 0.

Masking:
- With `maskEn` = 1 and `mask[i]` = 0, element i of `result` is not written and keeps its prior value (merge).
- With `maskEn` = 0, all elements are written.

Flags:
- `allZero` and `anyNeg` are computed over the full final `result` (including merged elements) and registered on the RUN→DONE edge.
- They hold until the next RUN→DONE edge.

Other rules:
- `start` while `ready` = 0 is ignored. It is not queued.
- Inputs changing after accept have no effect on the operation in flight.
- `result` holds after DONE until overwritten chunk-by-chunk by the next operation. During RUN, chunks already processed hold the new values and the rest hold the old values.

Reset (any state, including mid-RUN):
- Next state is IDLE, `idx` = 0, `result` = 0, `allZero` = 0, `anyNeg` = 0.
- After the reset edge, `done` = 0, `busy` = 0 and `ready` = 1.
- `start` asserted in the same cycle as `reset` is ignored.

## Timing
- N = `VECTOR_WIDTH`/`LANES` RUN cycles.
- Accept edge E0. Chunk k is written at edge E(k+1), for k = 0..N−1.
- `done` is high for exactly the one cycle after edge E_N. `ready` returns at edge E(N+1).
- Minimum spacing between accepts: N+2 edges.
- Degenerate case `LANES` = `VECTOR_WIDTH`: N = 1, and `done` is high in the cycle after E1.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Test plan
- Default parameters (N = 4), op 000, A[i] = i, B[i] = 10·i:
  - `done` is high exactly in the cycle after E4.
  - `result` = {0, 11, 22, …, 77}.
  - `allZero` = 0, `anyNeg` = 0.
  - `ready` = 1 again at E5.
- Wrap and flags:
  - op 000, A[i] = 0xFFFFFF, B[i] = 1 → all elements 0, `allZero` = 1.
  - op 001, A = 0, B = 1 → 0xFFFFFF, `anyNeg` = 1.
- Scalar and shifts:
  - `scalarMode` = 1, `scalarB` = 3, op 101, A[i] = 1 → all elements 8.
  - Repeat with `scalarB` = 24 → all elements 0.
- Mask merge:
  - Prior result all 0x000055.
  - `maskEn` = 1, `mask` = 8'b1010_0101, op 111, B = 0x0000AA → elements 0, 2, 5, 7 = 0xAA; the others remain 0x55.
- Busy and reset:
  - `start` pulsed at E2 of an operation with different operands is ignored; the final result matches the first operation only.
  - Separately, `reset` at E2 → the next cycle has `ready` = 1, `busy` = 0, `result` = 0, and `done` never asserts.
- Parametrisation:
  - `LANES` = 8 → single RUN cycle, `done` in the cycle after E1.
  - `LANES` = 3 with `VECTOR_WIDTH` = 8 → elaboration error.
